pattern_tx: RTL and testbench

Serial frame transmitter that emits a fixed 4-bit sync preamble (1,1,0,1) followed by a parallel-loaded payload, one bit per clock, MSB first. It is the transmit-side counterpart to the 1101 sequence-recognizer FSMs in the lab datapath. The preamble lets a downstream serial detector lock onto frame starts. It sits between a parallel producer, which raises `load`, and a single-bit serial line.

---
 rtl/pattern_tx.sv | 80 ++++++++
 tb/tb_pattern_tx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pattern_tx.sv
// Serial frame transmitter: 1101 sync preamble, then a parallel-loaded payload MSB first,
// then a single guard/STOP cycle that pulses done.
module pattern_tx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 o,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(DATA_BITS > 4 ? DATA_BITS : 4);
    // Indexed by counter: bit0..bit3 give the on-wire order 1,1,0,1.
    localparam logic [3:0] PREAMBLE = 4'b1011;

    typedef enum logic [1:0] {IDLE, PRE, DATA, STOP} state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [DATA_BITS-1:0] r_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sr    <= '0;
        end else begin
            case (r_state)
                // STOP accepts a new frame just like IDLE, so held load gives back-to-back frames.
                IDLE, STOP: begin
                    if (load) begin
                        r_sr    <= data_in;
                        r_cnt   <= '0;
                        r_state <= PRE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                PRE: begin
                    if (r_cnt == CW'(3)) begin
                        r_cnt   <= '0;
                        r_state <= DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DATA: begin
                    r_sr  <= r_sr << 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(DATA_BITS - 1))
                        r_state <= STOP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Moore decode: outputs depend on registers only.
    always_comb begin
        o    = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            PRE: begin
                o    = PREAMBLE[r_cnt[1:0]];
                busy = 1'b1;
            end
            DATA: begin
                o    = r_sr[DATA_BITS-1];
                busy = 1'b1;
            end
            STOP:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pattern_tx.sv
// Scoreboard bench for pattern_tx: per-cycle expected {o,busy,done} pushed when driven,
// popped and compared on the falling edge.
module tb_pattern_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ld0 = 1'b0, ld1 = 1'b0, ld2 = 1'b0;
    logic [7:0]  d0 = '0;
    logic [0:0]  d1 = '0;
    logic [31:0] d2 = '0;
    logic        o0, b0, dn0, o1, b1, dn1, o2, b2, dn2;

    pattern_tx #(.DATA_BITS(8))  u_dut8  (.clk(clk), .rst(rst), .load(ld0), .data_in(d0),
                                          .o(o0), .busy(b0), .done(dn0));
    pattern_tx #(.DATA_BITS(1))  u_dut1  (.clk(clk), .rst(rst), .load(ld1), .data_in(d1),
                                          .o(o1), .busy(b1), .done(dn1));
    pattern_tx #(.DATA_BITS(32)) u_dut32 (.clk(clk), .rst(rst), .load(ld2), .data_in(d2),
                                          .o(o2), .busy(b2), .done(dn2));

    typedef struct {
        logic        ld;
        logic [31:0] d;
        logic [2:0]  e;
    } step_t;

    typedef struct {
        int         dut;
        logic [2:0] e;
        string      tag;
        int         idx;
    } sb_t;

    step_t plan[$];
    sb_t   sb[$];
    int    total = 0;
    int    bad   = 0;

    function automatic logic [2:0] obs_of(input int dut);
        case (dut)
            0:       return {o0, b0, dn0};
            1:       return {o1, b1, dn1};
            default: return {o2, b2, dn2};
        endcase
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t it;
            logic [2:0] ob;
            it = sb.pop_front();
            ob = obs_of(it.dut);
            total++;
            assert (ob === it.e) else begin
                bad++;
                $error("FAIL %s[%0d] dut=%0d {o,busy,done} got=%b want=%b",
                       it.tag, it.idx, it.dut, ob, it.e);
            end
        end
    end

    task automatic add(input logic ld, input logic [31:0] d, input logic [2:0] e);
        step_t s;
        s.ld = ld; s.d = d; s.e = e;
        plan.push_back(s);
    endtask

    // One full frame of expected outputs; ld/ldd are the inputs driven during it.
    task automatic add_frame(input int nb, input logic [31:0] pay,
                             input logic ld, input logic [31:0] ldd);
        logic [3:0] pre;
        pre = 4'b1101;
        for (int i = 3; i >= 0; i--) add(ld, ldd, {pre[i], 2'b10});
        for (int i = nb - 1; i >= 0; i--) add(ld, ldd, {pay[i], 2'b10});
        add(ld, ldd, 3'b001);
    endtask

    task automatic play(input int dut, input string tag);
        int n;
        n = 0;
        while (plan.size() > 0) begin
            step_t s;
            sb_t   it;
            s = plan.pop_front();
            @(posedge clk);
            #1;
            case (dut)
                0:       begin ld0 = s.ld; d0 = s.d[7:0]; end
                1:       begin ld1 = s.ld; d1 = s.d[0:0]; end
                default: begin ld2 = s.ld; d2 = s.d;      end
            endcase
            it.dut = dut; it.e = s.e; it.tag = tag; it.idx = n;
            sb.push_back(it);
            n++;
        end
    endtask

    task automatic check_now(input int dut, input string tag, input logic [2:0] e);
        logic [2:0] ob;
        ob = obs_of(dut);
        total++;
        assert (ob === e) else begin
            bad++;
            $error("FAIL %s dut=%0d {o,busy,done} got=%b want=%b", tag, dut, ob, e);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_now(i, "reset", 3'b000);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single frame 8'hA5
        add(1'b1, 32'hA5, 3'b000);
        add_frame(8, 32'hA5, 1'b0, 32'h0);
        add(1'b0, 0, 3'b000); add(1'b0, 0, 3'b000);
        play(0, "single");

        // Loads during PRE and DATA are ignored
        add(1'b1, 32'hA5, 3'b000);
        add_frame(8, 32'hA5, 1'b0, 32'h0);
        plan[3].ld = 1'b1; plan[3].d = 32'h3C;
        plan[8].ld = 1'b1; plan[8].d = 32'h3C;
        for (int i = 0; i < 3; i++) add(1'b0, 0, 3'b000);
        play(0, "ignore");

        // Back-to-back: load held, 8'h00 presented during STOP
        add(1'b1, 32'hFF, 3'b000);
        add_frame(8, 32'hFF, 1'b1, 32'hFF);
        plan[13].d = 32'h00;
        add_frame(8, 32'h00, 1'b0, 32'h0);
        add(1'b0, 0, 3'b000); add(1'b0, 0, 3'b000);
        play(0, "b2b");

        // Abort during payload bit 3: async reset mid-cycle
        add(1'b1, 32'hA5, 3'b000);
        add_frame(8, 32'hA5, 1'b0, 32'h0);
        while (plan.size() > 8) void'(plan.pop_back());
        play(0, "pre_abort");
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_now(0, "async_rst", 3'b000);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) add(1'b0, 0, 3'b000);
        add(1'b1, 32'h81, 3'b000);
        add_frame(8, 32'h81, 1'b0, 32'h0);
        add(1'b0, 0, 3'b000); add(1'b0, 0, 3'b000);
        play(0, "abort");

        // DATA_BITS=1
        add(1'b1, 32'h1, 3'b000);
        add_frame(1, 32'h1, 1'b0, 32'h0);
        add(1'b0, 0, 3'b000); add(1'b0, 0, 3'b000);
        play(1, "db1");

        // DATA_BITS=32
        add(1'b1, 32'h8000_0001, 3'b000);
        add_frame(32, 32'h8000_0001, 1'b0, 32'h0);
        add(1'b0, 0, 3'b000); add(1'b0, 0, 3'b000);
        play(2, "db32");

        repeat (2) @(posedge clk);
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
